// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock frequency meter: FSM state encoding,
// default counter widths and the gate-length substitute used when a zero
// window length is programmed.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int C_CNT_W_DEF = 32;
  localparam int C_ERR_W_DEF = 16;

  // A zero gate length would give an empty window; run the shortest real one.
  localparam int C_GATE_ZERO_SUB = 1;

endpackage

// File: rtl/clk_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for a slow
// asynchronous clock sampled as data. O_rise is a one-cycle pulse, valid
// two system-clock edges after the input rises.
module clk_edge_sync (
  input  logic I_sys_clk,
  input  logic I_rst_n,
  input  logic I_async,
  output logic O_rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  // Resynchronize the input and keep its previous synchronized value
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= I_async;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign O_rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/clk_freq_meter.sv
// Gated frequency meter: counts rising edges of a sampled clock over a
// programmable window of system-clock cycles, range-checks each count and
// keeps a saturating count of failing windows.
// Optional feature macro: CLK_FREQ_METER_ERR_CNT_EN enables the error
// counter and I_clr_err; without it O_err_cnt is tied to zero.
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int C_CNT_W = C_CNT_W_DEF,
  parameter int C_ERR_W = C_ERR_W_DEF
) (
  input  logic               I_sys_clk,
  input  logic               I_rst_n,
  input  logic               I_meas_clk,
  input  logic               I_meas_en,
  input  logic [C_CNT_W-1:0] I_gate_cycles,
  input  logic [C_CNT_W-1:0] I_exp_min,
  input  logic [C_CNT_W-1:0] I_exp_max,
  input  logic               I_clr_err,
  output logic [C_CNT_W-1:0] O_meas_cnt,
  output logic               O_meas_vld,
  output logic               O_freq_ok,
  output logic               O_clk_lost,
  output logic [C_ERR_W-1:0] O_err_cnt,
  output logic               O_busy
);

  state_t state_reg;
  state_t state_next;

  logic [C_CNT_W-1:0] gate_cnt_reg;
  logic [C_CNT_W-1:0] edge_cnt_reg;
  logic [C_CNT_W-1:0] edge_cnt_next;
  logic [C_CNT_W-1:0] min_reg;
  logic [C_CNT_W-1:0] max_reg;
  logic [C_CNT_W-1:0] meas_cnt_reg;
  logic               freq_ok_reg;
  logic               clk_lost_reg;
  logic               meas_rise;
  logic               window_done;
  logic               window_ok;
  logic               meas_vld;
  logic               busy;

  clk_edge_sync u_edge_sync (
    .I_sys_clk (I_sys_clk),
    .I_rst_n   (I_rst_n),
    .I_async   (I_meas_clk),
    .O_rise    (meas_rise)
  );

  // Edge count including an edge seen in the current cycle, saturating
  always_comb begin
    edge_cnt_next = edge_cnt_reg;
    if (meas_rise && (edge_cnt_reg != {C_CNT_W{1'b1}})) begin
      edge_cnt_next = edge_cnt_reg + C_CNT_W'(1);
    end
  end

  // The final COUNT cycle still counts its edge, so the result uses edge_cnt_next
  assign window_done = (state_reg == COUNT) && I_meas_en &&
                       (gate_cnt_reg == C_CNT_W'(1));
  assign window_ok   = (edge_cnt_next >= min_reg) && (edge_cnt_next <= max_reg);

  // FSM state register
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; dropping the enable aborts any window in flight
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (I_meas_en) state_next = ARM;
      ARM:     state_next = I_meas_en ? COUNT : IDLE;
      COUNT: begin
        if (!I_meas_en) begin
          state_next = IDLE;
        end else if (gate_cnt_reg == C_CNT_W'(1)) begin
          state_next = REPORT;
        end
      end
      REPORT:  state_next = I_meas_en ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    meas_vld = (state_reg == REPORT);
    busy     = (state_reg != IDLE);
  end

  // Window datapath: latch settings in ARM, then gate down and count edges
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      min_reg      <= '0;
      max_reg      <= '0;
    end else begin
      case (state_reg)
        ARM: begin
          gate_cnt_reg <= (I_gate_cycles == '0) ? C_CNT_W'(C_GATE_ZERO_SUB)
                                                : I_gate_cycles;
          min_reg      <= I_exp_min;
          max_reg      <= I_exp_max;
          edge_cnt_reg <= '0;
        end
        COUNT: begin
          gate_cnt_reg <= gate_cnt_reg - C_CNT_W'(1);
          edge_cnt_reg <= edge_cnt_next;
        end
        default: ;
      endcase
    end
  end

  // Result registers change only on the edge entering REPORT
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      meas_cnt_reg <= '0;
      freq_ok_reg  <= 1'b0;
      clk_lost_reg <= 1'b0;
    end else if (window_done) begin
      meas_cnt_reg <= edge_cnt_next;
      freq_ok_reg  <= window_ok;
      clk_lost_reg <= (edge_cnt_next == '0);
    end
  end

`ifdef CLK_FREQ_METER_ERR_CNT_EN
  logic [C_ERR_W-1:0] err_cnt_reg;

  // Saturating failing-window counter; a clear request beats an increment
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      err_cnt_reg <= '0;
    end else if (I_clr_err) begin
      err_cnt_reg <= '0;
    end else if (window_done && !window_ok &&
                 (err_cnt_reg != {C_ERR_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + C_ERR_W'(1);
    end
  end

  assign O_err_cnt = err_cnt_reg;
`else
  logic unused_clr_err;
  assign unused_clr_err = I_clr_err;
  assign O_err_cnt      = '0;
`endif

  assign O_meas_cnt = meas_cnt_reg;
  assign O_meas_vld = meas_vld;
  assign O_freq_ok  = freq_ok_reg;
  assign O_clk_lost = clk_lost_reg;
  assign O_busy     = busy;

endmodule
